// File: rtl/seg_scan_drv_if.sv
// Seven-segment scan driver bus: display data/controls in, scanned pin drive and
// status out.
interface seg_scan_drv_if #(
   parameter int DIGITS = 4
);
   localparam int SEL_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp;
   logic                upd;
   logic                blank_lz;
   logic                disp_en;
   logic [SEL_W-1:0]    seg_sel;
   logic [DIGITS-1:0]   seg_an;
   logic [7:0]          seg_data;
   logic                frame_tick;
   logic                upd_pend;

   modport master (
      output data, dp, upd, blank_lz, disp_en,
      input  seg_sel, seg_an, seg_data, frame_tick, upd_pend
   );

   modport slave (
      input  data, dp, upd, blank_lz, disp_en,
      output seg_sel, seg_an, seg_data, frame_tick, upd_pend
   );
endinterface

// File: rtl/seg_scan_drv.sv
// Multiplexed seven-segment driver with frame-synchronous double buffering,
// decimal points, leading-zero blanking and display enable.
module seg_scan_drv #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DELAY = 100_000
) (
   input  logic          clk_100M,
   input  logic          rst_n,
   seg_scan_drv_if.slave bus
);
   localparam int CNT_W = $clog2(SCAN_DELAY);
   localparam int SEL_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;

   logic [CNT_W-1:0]    scan_cnt;
   logic [SEL_W-1:0]    sel;
   logic [4*DIGITS-1:0] pending;
   logic [DIGITS-1:0]   pending_dp;
   logic [4*DIGITS-1:0] shadow;
   logic [DIGITS-1:0]   shadow_dp;
   logic                upd_pend;
   logic                frame_tick;
   logic [SEL_W-1:0]    seg_sel_q;
   logic [DIGITS-1:0]   seg_an_q;
   logic [7:0]          seg_data_q;

   logic                scan_en;
   logic                wrap;
   logic [DIGITS-1:0]   lz;
   logic                zero_above;
   logic [3:0]          nib;
   logic [6:0]          seg_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   assign scan_en = (scan_cnt == CNT_W'(SCAN_DELAY - 1));
   assign wrap    = scan_en && (sel == SEL_W'(DIGITS - 1));

   // lz[i]: shadow nibbles i..DIGITS-1 are all zero; digit 0 is never a candidate
   always_comb begin
      lz         = '0;
      zero_above = 1'b1;
      for (int unsigned k = 0; k < DIGITS - 1; k++) begin
         zero_above = zero_above & (shadow[4*(DIGITS-1-k) +: 4] == 4'h0);
         lz[DIGITS-1-k] = zero_above;
      end
      nib     = shadow[{sel, 2'b00} +: 4];
      seg_nxt = (bus.blank_lz && lz[sel]) ? 7'h7F : hex7(nib);
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt   <= '0;
         sel        <= '0;
         pending    <= '0;
         pending_dp <= '0;
         shadow     <= '0;
         shadow_dp  <= '0;
         upd_pend   <= 1'b0;
         frame_tick <= 1'b0;
         seg_sel_q  <= '0;
         seg_an_q   <= '1;
         seg_data_q <= '1;
      end else begin
         if (scan_en) begin
            scan_cnt <= '0;
            sel      <= (sel == SEL_W'(DIGITS - 1)) ? '0 : sel + SEL_W'(1);
         end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
         end
         frame_tick <= wrap;

         // A strobe on the wrap cycle overrides the clear: new data waits one more frame
         if (wrap && upd_pend) begin
            shadow    <= pending;
            shadow_dp <= pending_dp;
            upd_pend  <= 1'b0;
         end
         if (bus.upd) begin
            pending    <= bus.data;
            pending_dp <= bus.dp;
            upd_pend   <= 1'b1;
         end

         seg_sel_q <= sel;
         if (bus.disp_en) begin
            seg_an_q   <= ~({{(DIGITS-1){1'b0}}, 1'b1} << sel);
            seg_data_q <= {~shadow_dp[sel], seg_nxt};
         end else begin
            seg_an_q   <= '1;
            seg_data_q <= '1;
         end
      end
   end

   assign bus.seg_sel    = seg_sel_q;
   assign bus.seg_an     = seg_an_q;
   assign bus.seg_data   = seg_data_q;
   assign bus.frame_tick = frame_tick;
   assign bus.upd_pend   = upd_pend;
endmodule
